// File: rtl/ram_dp_be.sv
// ram_dp_be: true dual-port RAM on a single clock.
//   - Per-byte write enables on both ports.
//   - Selectable same-port read-during-write behaviour (RDW_MODE).
//   - Optional second output register stage (OUT_REG).
//   - Hardware clear engine that fills every word with INIT_VALUE after reset
//     or on a clr pulse; busy is high while it runs and the user ports are
//     ignored during that time.
// Optional feature macro: RAM_COLLISION_DETECT_EN adds the coll output, which
// flags a same-address dual write with overlapping byte enables.
module ram_dp_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  output logic                    busy,
  input  logic                    ena,
  input  logic [DATA_WIDTH/8-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [DATA_WIDTH-1:0]   dina,
  output logic [DATA_WIDTH-1:0]   douta,
  input  logic                    enb,
  input  logic [DATA_WIDTH/8-1:0] web,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  input  logic [DATA_WIDTH-1:0]   dinb,
  output logic [DATA_WIDTH-1:0]   doutb
`ifdef RAM_COLLISION_DETECT_EN
  ,
  output logic                    coll
`endif
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   clrAddr_q;
  logic                    busy_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [DATA_WIDTH-1:0]   douta_q, douta_d;
  logic [DATA_WIDTH-1:0]   doutb_q, doutb_d;

  logic accA;
  logic accB;

  // A user access only happens when the clear engine is idle and reset is low.
  assign accA = ena && !busy_q && !rst;
  assign accB = enb && !busy_q && !rst;

  assign busy = busy_q;

  // Clear engine: walks every address once, then returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clrAddr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q   <= CLEAR;
            clrAddr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        CLEAR: begin
          clrAddr_q <= clrAddr_q + 1'b1;
          if (clrAddr_q == {ADDR_WIDTH{1'b1}}) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Memory array writes; port A is assigned last so it wins overlapping bytes.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clrAddr_q] <= INIT_VALUE;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (accB && web[b]) begin
          mem[addrb][b*8 +: 8] <= dinb[b*8 +: 8];
        end
        if (accA && wea[b]) begin
          mem[addra][b*8 +: 8] <= dina[b*8 +: 8];
        end
      end
    end
  end

  // Next read data per port: old stored word, or own new bytes in write-first mode.
  always_comb begin
    douta_d = douta_q;
    doutb_d = doutb_q;
    if (accA) begin
      for (int b = 0; b < NB; b++) begin
        douta_d[b*8 +: 8] = (RDW_MODE == 0 && wea[b]) ? dina[b*8 +: 8]
                                                      : mem[addra][b*8 +: 8];
      end
    end
    if (accB) begin
      for (int b = 0; b < NB; b++) begin
        doutb_d[b*8 +: 8] = (RDW_MODE == 0 && web[b]) ? dinb[b*8 +: 8]
                                                      : mem[addrb][b*8 +: 8];
      end
    end
  end

  // First read register stage; holds when its port is not accessed.
  always_ff @(posedge clk) begin
    if (rst) begin
      douta_q <= '0;
      doutb_q <= '0;
    end else begin
      douta_q <= douta_d;
      doutb_q <= doutb_d;
    end
  end

`ifdef RAM_COLLISION_DETECT_EN
  logic collRaw;
  logic coll_q;

  assign collRaw = accA && accB && (addra == addrb) && (|(wea & web));

  // Collision flag aligned with the first read stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= collRaw;
    end
  end
`endif

  generate
    if (OUT_REG != 0) begin : g_outReg
      logic [DATA_WIDTH-1:0] douta2_q;
      logic [DATA_WIDTH-1:0] doutb2_q;

      // Second output stage, loaded every cycle from the first stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          douta2_q <= '0;
          doutb2_q <= '0;
        end else begin
          douta2_q <= douta_q;
          doutb2_q <= doutb_q;
        end
      end

      assign douta = douta2_q;
      assign doutb = doutb2_q;

`ifdef RAM_COLLISION_DETECT_EN
      logic coll2_q;

      // Delay the collision flag to match the two-cycle read latency.
      always_ff @(posedge clk) begin
        if (rst) begin
          coll2_q <= 1'b0;
        end else begin
          coll2_q <= coll_q;
        end
      end

      assign coll = coll2_q;
`endif
    end else begin : g_noOutReg
      assign douta = douta_q;
      assign doutb = doutb_q;
`ifdef RAM_COLLISION_DETECT_EN
      assign coll = coll_q;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: drives two ram_dp_be instances with identical stimulus.
//   dut0: write-first, no output register. dut1: read-first, output register.
// A word-level memory model produces expected outputs that are queued with
// the cycle they are due; an independent monitor pops and compares them.
module tb_ram_dp_be;

  localparam int DEPTH = 16;
  localparam logic [31:0] INIT = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic        ena, enb;
  logic [3:0]  wea, web, addra, addrb;
  logic [31:0] dina, dinb;
  logic        busy0, busy1;
  logic [31:0] douta0, doutb0, douta1, doutb1;
`ifdef RAM_COLLISION_DETECT_EN
  logic        coll0, coll1;
`endif

  always #5 clk = ~clk;

  int cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(0), .OUT_REG(0), .INIT_VALUE(INIT)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy0),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0)
`ifdef RAM_COLLISION_DETECT_EN
    , .coll(coll0)
`endif
  );

  ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(1), .OUT_REG(1), .INIT_VALUE(INIT)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy1),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1)
`ifdef RAM_COLLISION_DETECT_EN
    , .coll(coll1)
`endif
  );

  typedef struct {
    int          due;
    int          chan;
    logic [31:0] val;
  } exp_t;

  exp_t        sbQ[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] holdA0, holdB0, holdA1, holdB1;
  int          busyLeft = 0;
  bit          modelOn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cycleCount, act, exp);
    end
  endtask

  task automatic push(input int due, input int chan, input logic [31:0] val);
    exp_t e;
    e.due  = due;
    e.chan = chan;
    e.val  = val;
    sbQ.push_back(e);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] oldW, input logic [31:0] newW, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = be[b] ? newW[b*8 +: 8] : oldW[b*8 +: 8];
    return r;
  endfunction

  // Apply one cycle of stimulus and queue what the outputs must show afterwards.
  task automatic applyStimulus(input logic ea, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] da,
                               input logic eb, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db,
                               input logic c);
    int          due;
    logic [31:0] oldA, oldB;
    logic        expColl;
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    clr = c;
    due = cycleCount + 1;
    expColl = 1'b0;
    if (modelOn) begin
      if (busyLeft > 0) begin
        busyLeft--;
      end else begin
        oldA = model[aa];
        oldB = model[ab];
        if (ea) begin holdA0 = merge(oldA, da, wa); holdA1 = oldA; end
        if (eb) begin holdB0 = merge(oldB, db, wb); holdB1 = oldB; end
        if (eb) model[ab] = merge(model[ab], db, wb);
        if (ea) model[aa] = merge(model[aa], da, wa);
        expColl = ea && eb && (aa == ab) && ((wa & wb) != 4'h0);
        if (c) begin
          busyLeft = DEPTH;
          for (int i = 0; i < DEPTH; i++) model[i] = INIT;
        end
      end
      push(due, 0, holdA0);
      push(due, 1, holdB0);
      push(due + 1, 2, holdA1);
      push(due + 1, 3, holdB1);
      push(due, 4, {31'b0, busyLeft > 0});
      push(due, 5, {31'b0, busyLeft > 0});
`ifdef RAM_COLLISION_DETECT_EN
      push(due, 6, {31'b0, expColl});
      push(due + 1, 7, {31'b0, expColl});
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleTick();
    applyStimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic randTick(input int clrOneIn);
    applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
                  (clrOneIn > 0) && ($urandom_range(0, clrOneIn - 1) == 0));
  endtask

  // Pulse reset, check reset outputs and the clear length, then resync the model.
  task automatic doReset(input int holdCycles);
    int n;
    bit fell;
    modelOn = 1'b0;
    repeat (2) idleTick();
    rst = 1'b1;
    repeat (holdCycles) randTick(0);
    checkOutput("rstBusy0", {31'b0, busy0}, 32'd1);
    checkOutput("rstBusy1", {31'b0, busy1}, 32'd1);
    checkOutput("rstDouta0", douta0, 32'h0);
    checkOutput("rstDoutb0", doutb0, 32'h0);
    checkOutput("rstDouta1", douta1, 32'h0);
    checkOutput("rstDoutb1", doutb1, 32'h0);
`ifdef RAM_COLLISION_DETECT_EN
    checkOutput("rstColl0", {31'b0, coll0}, 32'd0);
    checkOutput("rstColl1", {31'b0, coll1}, 32'd0);
`endif
    rst = 1'b0;
    n = 0;
    fell = 1'b0;
    while (!fell && n < 100) begin
      randTick(0);
      n++;
      if (busy0 == 1'b0) fell = 1'b1;
    end
    checkOutput("clearCycles", n, DEPTH);
    checkOutput("clearBusy1", {31'b0, busy1}, 32'd0);
    checkOutput("clearHoldA0", douta0, 32'h0);
    checkOutput("clearHoldB1", doutb1, 32'h0);
    for (int i = 0; i < DEPTH; i++) model[i] = INIT;
    holdA0 = '0; holdB0 = '0; holdA1 = '0; holdB1 = '0;
    busyLeft = 0;
    modelOn = 1'b1;
  endtask

  function automatic string chanName(input int chan);
    case (chan)
      0: return "douta0";
      1: return "doutb0";
      2: return "douta1";
      3: return "doutb1";
      4: return "busy0";
      5: return "busy1";
      6: return "coll0";
      default: return "coll1";
    endcase
  endfunction

  // Monitor: compare every queued expectation that is due this cycle.
  always @(negedge clk) begin : monitor
    int          i;
    logic [31:0] act;
    i = 0;
    while (i < sbQ.size()) begin
      if (sbQ[i].due == cycleCount) begin
        case (sbQ[i].chan)
          0: act = douta0;
          1: act = doutb0;
          2: act = douta1;
          3: act = doutb1;
          4: act = {31'b0, busy0};
          5: act = {31'b0, busy1};
`ifdef RAM_COLLISION_DETECT_EN
          6: act = {31'b0, coll0};
          7: act = {31'b0, coll1};
`endif
          default: act = 32'hX;
        endcase
        checkOutput(chanName(sbQ[i].chan), act, sbQ[i].val);
        sbQ.delete(i);
      end else if (sbQ[i].due < cycleCount) begin
        checks++;
        failures++;
        $display("[TB] FAIL stale %s: due %0d now %0d", chanName(sbQ[i].chan), sbQ[i].due, cycleCount);
        sbQ.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    rst = 1'b0; clr = 1'b0;
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    holdA0 = '0; holdB0 = '0; holdA1 = '0; holdB1 = '0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset and clear");
    doReset(3);
    for (int a = 0; a < DEPTH; a++)
      applyStimulus(1'b1, 4'h0, 4'(a), 32'h0, 1'b1, 4'h0, 4'(DEPTH - 1 - a), 32'h0, 1'b0);

    $display("[TB] byte enables");
    applyStimulus(1'b1, 4'hF, 4'd3, 32'h11223344, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    applyStimulus(1'b1, 4'b0010, 4'd3, 32'hFFFFFFFF, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0, 1'b0);

    $display("[TB] read-during-write");
    applyStimulus(1'b1, 4'hF, 4'd5, 32'h1, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    applyStimulus(1'b1, 4'hF, 4'd5, 32'h2, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    applyStimulus(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);

    $display("[TB] dual-write collisions");
    applyStimulus(1'b1, 4'hF, 4'd7, 32'hAAAAAAAA, 1'b1, 4'hF, 4'd7, 32'hBBBBBBBB, 1'b0);
    applyStimulus(1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0, 1'b0);
    applyStimulus(1'b1, 4'b0011, 4'd9, 32'h01020304, 1'b1, 4'b0110, 4'd9, 32'h0A0B0C0D, 1'b0);
    applyStimulus(1'b1, 4'b0011, 4'd10, 32'h11111111, 1'b1, 4'b1100, 4'd10, 32'h22222222, 1'b0);
    applyStimulus(1'b1, 4'h0, 4'd9, 32'h0, 1'b1, 4'h0, 4'd10, 32'h0, 1'b0);
    applyStimulus(1'b1, 4'hF, 4'd11, 32'hCAFEF00D, 1'b1, 4'h0, 4'd11, 32'h0, 1'b0);

    $display("[TB] random traffic");
    repeat (400) randTick(50);
    repeat (DEPTH + 1) idleTick();

    $display("[TB] clr with same-cycle access, writes while busy");
    applyStimulus(1'b1, 4'hF, 4'd2, 32'h12345678, 1'b1, 4'h0, 4'd2, 32'h0, 1'b1);
    repeat (DEPTH) applyStimulus(1'b1, 4'hF, 4'($urandom_range(0, 15)), $urandom,
                                 1'b1, 4'hF, 4'($urandom_range(0, 15)), $urandom, 1'b0);
    for (int a = 0; a < DEPTH; a++)
      applyStimulus(1'b1, 4'h0, 4'(a), 32'h0, 1'b1, 4'h0, 4'(a), 32'h0, 1'b0);

    $display("[TB] reset mid-clear");
    applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1);
    repeat (4) randTick(0);
    doReset(2);
    for (int a = 0; a < DEPTH; a++)
      applyStimulus(1'b1, 4'h0, 4'(a), 32'h0, 1'b1, 4'h0, 4'(DEPTH - 1 - a), 32'h0, 1'b0);
    repeat (100) randTick(0);

    modelOn = 1'b0;
    repeat (3) idleTick();
    checkOutput("queueDrained", sbQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_dp_be.md
# ram_dp_be

Parametrised true dual-port RAM with per-byte write enables, selectable read-during-write mode, an optional output pipeline stage and a built-in memory clear engine. It replaces the plain two-port word RAM used for the bcrypt S-box and P-array storage behind the Epiphany/AXI bridge. Both ports run on one clock. After reset or on command, the block clears its contents in hardware, so the host never has to zero-fill the RAM over the bus.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- ADDR_WIDTH, 10, address width; depth is 2**ADDR_WIDTH.
- RDW_MODE, 0, same-port read-during-write: 0 = write-first (dout shows the new word), 1 = read-first (dout shows the old word).
- OUT_REG, 0, 1 adds an output register stage, so read latency is 2.
- INIT_VALUE, 0, word written to every address by the clear engine.

Ports:
- clk  in  1  single clock for both ports.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  one-cycle pulse that starts a clear; ignored while busy=1.
- busy  out  1  high while the clear engine runs.
- ena  in  1  port A enable.
- wea  in  DATA_WIDTH/8  port A byte write enables.
- addra  in  ADDR_WIDTH  port A address.
- dina  in  DATA_WIDTH  port A write data.
- douta  out  DATA_WIDTH  port A read data.
- enb, web, addrb, dinb, doutb: the same as port A, for port B.
- coll  out  1  collision flag; present only with RAM_COLLISION_DETECT_EN.

## Operation
- Clear engine FSM:
  - States: IDLE, CLEAR.
  - rst=1 forces CLEAR with the counter at 0.
  - In IDLE, clr=1 enters CLEAR with the counter at 0.
  - In CLEAR, the engine writes INIT_VALUE to mem[counter] each cycle and increments the counter.
  - After writing address 2**ADDR_WIDTH-1, the FSM returns to IDLE.
  - busy=1 exactly in CLEAR, and also while rst=1.
- While busy=1, both user ports are ignored: no writes, and douta/doutb hold their values.
- Port X access with enX=1:
  - Bytes i where weX[i]=1 are written from dinX.
  - doutX is loaded with the addressed word.
  - With RDW_MODE=0, written bytes show the new data and unwritten bytes show the stored data.
  - With RDW_MODE=1, all bytes show the old word.
- With enX=0 there is no access and doutX holds.
- Cross-port behaviour at the same address in the same cycle:
  - A read on one port returns the old word, regardless of RDW_MODE.
  - If both ports write, port A wins on overlapping bytes; non-overlapping bytes from both ports are stored.
  - Each port's dout follows its own RDW_MODE rule using only its own din.
- OUT_REG=1 registers doutX once more, with the stage enabled every cycle.
- Reset values: douta=0, doutb=0, busy=1 (busy stays 1 through the following clear), coll=0. The output stage also resets to 0.
- rst asserted mid-clear restarts the clear at address 0.

## Timing
- Read latency: address at edge N gives data valid after edge N+1 (OUT_REG=0) or after edge N+2 (OUT_REG=1).
- A write at edge N is readable on either port by a read issued at edge N+1.
- A clear takes exactly 2**ADDR_WIDTH cycles.
  - After rst falls, busy falls on the 2**ADDR_WIDTH-th rising edge.
  - The first user access is accepted in the cycle busy=0 is first sampled.
- clr at edge N, taken from IDLE, gives busy=1 after edge N.
- clr asserted in the same cycle as user accesses: those accesses are still performed, because busy was 0 when they were sampled.

## Configuration
- RAM_COLLISION_DETECT_EN defined:
  - Adds port coll.
  - coll is 1 for one cycle after an edge where both ports wrote the same address with overlapping byte enables.
  - coll timing follows the OUT_REG latency.
- RAM_COLLISION_DETECT_EN undefined: the coll port and its logic are absent. Data behaviour is identical.

## Test plan
- Reset and clear, with ADDR_WIDTH=4 and INIT_VALUE=32'hA5A5A5A5:
  - Pulse rst, then release it: busy stays 1 for 16 cycles.
  - Reading all 16 addresses then returns A5A5A5A5.
- Byte enables, RDW_MODE=0:
  - Write A[3]=32'h11223344 with wea=4'hF, then write A[3]=32'hFFFFFFFF with wea=4'b0010.
  - douta after the second write is 32'h1122FF44; a port B read of address 3 returns the same word.
- Read-first mode, RDW_MODE=1:
  - mem[5]=32'h1, then write 32'h2 to address 5.
  - douta=32'h1; the next read returns 32'h2.
- Dual-write collision:
  - A writes 32'hAAAAAAAA and B writes 32'hBBBBBBBB to address 7; wea=4'hF, web=4'hF.
  - mem[7]=32'hAAAAAAAA; coll=1 for one cycle when the macro is defined.
- OUT_REG=1 and mid-clear reset:
  - Read latency measures 2 cycles.
  - Assert rst 5 cycles into a clear: busy remains 1 for a further full 2**ADDR_WIDTH cycles after rst falls.
  - A write attempted during busy leaves memory unchanged.
